// File: rtl/multi_clock_freq_meter.sv
// Multi-channel frequency meter: counts ticks of NUM_CLKS asynchronous clocks
// over a programmable (or open-ended) window of clk cycles.
module multi_clock_freq_meter #(
    parameter int NUM_CLKS      = 6,
    parameter int COUNTER_WIDTH = 40,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_CLKS-1:0]               count_clk,
    input  logic [NUM_CLKS-1:0]               count_reset_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              clear,
    input  logic                              continuous,
    input  logic [COUNTER_WIDTH-1:0]          window_cycles,
    output logic                              busy,
    output logic                              done,
    output logic                              counts_valid,
    output logic [COUNTER_WIDTH-1:0]          elapsed,
    output logic [NUM_CLKS*COUNTER_WIDTH-1:0] counts,
    output logic [NUM_CLKS-1:0]               chan_err,
    output logic                              window_overflow
);

    localparam int W = COUNTER_WIDTH;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic [W-1:0] f_bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] f_gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int k = W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    logic [NUM_CLKS*W-1:0] w_sync_val;
    logic [NUM_CLKS-1:0]   w_rst_sync;

    for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
        logic [W-1:0]           r_bin;
        logic [W-1:0]           r_gray;
        logic [W-1:0]           r_sync [SYNC_STAGES];
        logic [SYNC_STAGES-1:0] r_rst_sync;

        always_ff @(posedge count_clk[g]) begin
            if (!count_reset_n[g]) begin
                r_bin  <= '0;
                r_gray <= '0;
            end else begin
                r_bin  <= r_bin + ONE;
                r_gray <= f_bin2gray(r_bin);
            end
        end

        // Gray code guarantees at most one bit in flight when sampled by clk.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int s = 0; s < SYNC_STAGES; s++) begin
                    r_sync[s] <= '0;
                end
                r_rst_sync <= '0;
            end else begin
                r_sync[0] <= r_gray;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    r_sync[s] <= r_sync[s-1];
                end
                r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], count_reset_n[g]};
            end
        end

        assign w_sync_val[g*W +: W] = f_gray2bin(r_sync[SYNC_STAGES-1]);
        assign w_rst_sync[g]        = r_rst_sync[SYNC_STAGES-1];
    end

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_valid;
    logic                  r_ovf;
    logic [W-1:0]          r_elapsed;
    logic [W-1:0]          r_win_len;
    logic [NUM_CLKS*W-1:0] r_snap;
    logic [NUM_CLKS*W-1:0] r_counts;
    logic [NUM_CLKS-1:0]   r_chan_err;

    logic                  w_lim_hit;
    logic                  w_ovf_hit;
    logic                  w_win_end;
    logic [NUM_CLKS-1:0]   w_err_next;
    logic [NUM_CLKS*W-1:0] w_delta;

    assign w_lim_hit  = (r_win_len != '0) && (r_elapsed == r_win_len - ONE);
    assign w_ovf_hit  = (r_win_len == '0) && (r_elapsed == '1);
    assign w_win_end  = w_lim_hit || stop || w_ovf_hit;
    assign w_err_next = r_chan_err | ~w_rst_sync;

    // Modular subtraction makes counter wrap inside a window harmless.
    always_comb begin
        w_delta = '0;
        for (int i = 0; i < NUM_CLKS; i++) begin
            if (!w_err_next[i]) begin
                w_delta[i*W +: W] = w_sync_val[i*W +: W] - r_snap[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_elapsed  <= '0;
            r_win_len  <= '0;
            r_snap     <= '0;
            r_counts   <= '0;
            r_chan_err <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_win_len  <= window_cycles;
                        r_snap     <= w_sync_val;
                        r_elapsed  <= '0;
                        r_chan_err <= '0;
                        r_ovf      <= 1'b0;
                    end else if (clear) begin
                        r_counts   <= '0;
                        r_valid    <= 1'b0;
                        r_chan_err <= '0;
                        r_ovf      <= 1'b0;
                        r_elapsed  <= '0;
                    end
                end
                S_RUN: begin
                    if (w_win_end) begin
                        r_counts   <= w_delta;
                        r_valid    <= 1'b1;
                        r_done     <= 1'b1;
                        r_chan_err <= w_err_next;
                        r_ovf      <= r_ovf | w_ovf_hit;
                        if (continuous && !stop) begin
                            r_snap    <= w_sync_val;
                            r_elapsed <= '0;
                            r_win_len <= window_cycles;
                        end else begin
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            // Saturate on overflow so the result reads all-ones.
                            r_elapsed <= w_ovf_hit ? r_elapsed : r_elapsed + ONE;
                        end
                    end else begin
                        // Window timing must not be disturbed by a clear while running.
                        r_elapsed <= r_elapsed + ONE;
                        if (clear) begin
                            r_counts   <= '0;
                            r_valid    <= 1'b0;
                            r_chan_err <= '0;
                            r_ovf      <= 1'b0;
                        end else begin
                            r_chan_err <= w_err_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign counts_valid    = r_valid;
    assign elapsed         = r_elapsed;
    assign counts          = r_counts;
    assign chan_err        = r_chan_err;
    assign window_overflow = r_ovf;

endmodule

// File: tb/tb_multi_clock_freq_meter.sv
// Bench for multi_clock_freq_meter: expected tick counts are derived from
// window duration divided by each channel's clock period.
`timescale 1ns/100ps
module tb_multi_clock_freq_meter;

    localparam int  N    = 6;
    localparam int  W    = 40;
    localparam int  W8   = 8;
    localparam real TCLK = 12.0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, c4 = 1'b0, c5 = 1'b0;
    logic [N-1:0] count_clk;
    logic [N-1:0] count_reset_n = '0;

    logic         start = 1'b0, stop = 1'b0, clear = 1'b0, continuous = 1'b0;
    logic [W-1:0] window_cycles = '0;
    logic         busy, done, counts_valid, window_overflow;
    logic [W-1:0] elapsed;
    logic [N*W-1:0] counts;
    logic [N-1:0] chan_err;

    logic          start8 = 1'b0, stop8 = 1'b0, clear8 = 1'b0, cont8 = 1'b0;
    logic [W8-1:0] win8 = '0;
    logic          busy8, done8, valid8, ovf8;
    logic [W8-1:0] elapsed8;
    logic [2*W8-1:0] counts8;
    logic [1:0]    err8;
    logic [1:0]    count_clk8;
    logic [1:0]    count_reset_n8;

    int  checks = 0;
    int  failures = 0;
    int  half3, half4, half5;
    real per [N];

    always #6 clk = ~clk;
    always @(posedge clk) c1 <= ~c1;
    initial begin #1; forever #4 c2 = ~c2; end
    initial begin half3 = $urandom_range(3, 20); #0.3; forever #(half3) c3 = ~c3; end
    initial begin half4 = $urandom_range(3, 20); #0.7; forever #(half4) c4 = ~c4; end
    initial begin half5 = $urandom_range(3, 20); #0.9; forever #(half5) c5 = ~c5; end

    assign count_clk      = {c5, c4, c3, c2, c1, clk};
    assign count_clk8     = {c2, clk};
    assign count_reset_n8 = {count_reset_n[2], count_reset_n[0]};

    multi_clock_freq_meter #(.NUM_CLKS(N), .COUNTER_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .count_clk(count_clk), .count_reset_n(count_reset_n),
        .start(start), .stop(stop), .clear(clear), .continuous(continuous),
        .window_cycles(window_cycles), .busy(busy), .done(done), .counts_valid(counts_valid),
        .elapsed(elapsed), .counts(counts), .chan_err(chan_err), .window_overflow(window_overflow)
    );

    multi_clock_freq_meter #(.NUM_CLKS(2), .COUNTER_WIDTH(W8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset_n(reset_n), .count_clk(count_clk8), .count_reset_n(count_reset_n8),
        .start(start8), .stop(stop8), .clear(clear8), .continuous(cont8),
        .window_cycles(win8), .busy(busy8), .done(done8), .counts_valid(valid8),
        .elapsed(elapsed8), .counts(counts8), .chan_err(err8), .window_overflow(ovf8)
    );

    function automatic logic [W-1:0] cnt(input int i);
        return counts[i*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [63:0] obs, input longint lo, input longint hi);
        checks++;
        assert (((longint'(obs) >= lo) && (longint'(obs) <= hi)) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference: a channel of period p sees ncyc*TCLK/p ticks, +-1 for quantisation.
    task automatic check_chans(input string tag, input int ncyc, input logic [N-1:0] errmask);
        real e;
        for (int i = 0; i < N; i++) begin
            if (errmask[i]) begin
                chk($sformatf("%s_ch%0d_zero", tag, i), 64'(cnt(i)), 64'd0);
            end else begin
                e = real'(ncyc) * TCLK / per[i];
                chk_rng($sformatf("%s_ch%0d", tag, i), 64'(cnt(i)),
                        longint'($floor(e)) - 1, longint'($ceil(e)) + 1);
            end
        end
    endtask

    task automatic wait_done(input string tag, input bit sel8, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sel8 ? done8 : done) !== 1'b1 && n < maxc);
        chk({tag, "_done_seen"}, 64'(sel8 ? done8 : done), 64'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_open(input string tag, input int len);
        pulse_start();
        repeat (len - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_elapsed"}, 64'(elapsed), 64'(len));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        check_chans(tag, len, '0);
    endtask

    initial begin
        int n;
        int len;
        logic [63:0] sum;
        bit saw;

        #1;
        per[0] = TCLK;
        per[1] = 2.0 * TCLK;
        per[2] = 8.0;
        per[3] = 2.0 * real'(half3);
        per[4] = 2.0 * real'(half4);
        per[5] = 2.0 * real'(half5);

        repeat (10) @(negedge clk);
        count_reset_n = '1;
        repeat (5) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(counts_valid), 64'd0);
        chk("rst_elapsed", 64'(elapsed), 64'd0);
        chk("rst_counts_or", 64'(|counts), 64'd0);
        chk("rst_chan_err", 64'(chan_err), 64'd0);
        chk("rst_ovf", 64'(window_overflow), 64'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Fixed 1000-cycle window: done 1001 cycles after the start cycle.
        window_cycles = 1000;
        pulse_start();
        chk("t1_busy_run", 64'(busy), 64'd1);
        wait_done("t1", 1'b0, 1200, n);
        chk("t1_latency", 64'(n), 64'd1000);
        chk("t1_elapsed", 64'(elapsed), 64'd1000);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_valid", 64'(counts_valid), 64'd1);
        check_chans("t1", 1000, '0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);

        window_cycles = 10000;
        pulse_start();
        wait_done("t2", 1'b0, 10200, n);
        chk("t2_latency", 64'(n), 64'd10000);
        chk("t2_elapsed", 64'(elapsed), 64'd10000);
        chk("t2_chan_err", 64'(chan_err), 64'd0);
        chk("t2_valid", 64'(counts_valid), 64'd1);
        check_chans("t2", 10000, '0);

        len = $urandom_range(50, 4000);
        window_cycles = W'(len);
        pulse_start();
        wait_done("trnd", 1'b0, 4200, n);
        chk("trnd_latency", 64'(n), 64'(len));
        chk("trnd_elapsed", 64'(elapsed), 64'(len));
        check_chans("trnd", len, '0);

        window_cycles = 0;
        run_open("t3", 2500);
        run_open("t3r", $urandom_range(300, 3000));
        chk("t3_ovf", 64'(window_overflow), 64'd0);

        // Continuous 100-cycle windows with no gap, then stop mid-window.
        continuous = 1'b1;
        window_cycles = 100;
        pulse_start();
        wait_done("t4w1", 1'b0, 200, n);
        chk("t4w1_latency", 64'(n), 64'd100);
        sum = 64'(cnt(0));
        for (int w = 2; w <= 5; w++) begin
            wait_done($sformatf("t4w%0d", w), 1'b0, 200, n);
            chk($sformatf("t4w%0d_spacing", w), 64'(n), 64'd100);
            chk($sformatf("t4w%0d_busy", w), 64'(busy), 64'd1);
            sum += 64'(cnt(0));
        end
        chk_rng("t4_sum_ch0", sum, 499, 501);
        repeat (39) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("t4_stop_done", 64'(done), 64'd1);
        chk("t4_stop_elapsed", 64'(elapsed), 64'd40);
        chk("t4_stop_busy", 64'(busy), 64'd0);
        chk_rng("t4_stop_ch0", 64'(cnt(0)), 39, 41);
        continuous = 1'b0;

        // Channel 3 reset inside the window.
        window_cycles = 2000;
        pulse_start();
        repeat (500) @(negedge clk);
        @(negedge c3); count_reset_n[3] = 1'b0;
        repeat (20) @(posedge c3);
        @(negedge c3); count_reset_n[3] = 1'b1;
        wait_done("t5", 1'b0, 2000, n);
        chk("t5_chan_err", 64'(chan_err), 64'h08);
        chk("t5_valid", 64'(counts_valid), 64'd1);
        check_chans("t5", 2000, 6'b001000);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("t5_clr_err", 64'(chan_err), 64'd0);
        chk("t5_clr_counts", 64'(|counts), 64'd0);
        chk("t5_clr_valid", 64'(counts_valid), 64'd0);
        chk("t5_clr_elapsed", 64'(elapsed), 64'd0);

        // 8-bit instance: open-ended window overflows after 256 cycles.
        win8 = 0;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        wait_done("t8ovf", 1'b1, 400, n);
        chk("t8ovf_latency", 64'(n), 64'd256);
        chk("t8ovf_flag", 64'(ovf8), 64'd1);
        chk("t8ovf_elapsed", 64'(elapsed8), 64'hFF);
        chk("t8ovf_busy", 64'(busy8), 64'd0);

        // Back-to-back 8-bit windows cover >512 consecutive ticks, so some window spans the wrap.
        win8 = 150;
        cont8 = 1'b1;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            wait_done($sformatf("t8w%0d", w), 1'b1, 300, n);
            chk($sformatf("t8w%0d_len", w), 64'(n), 64'd150);
            chk_rng($sformatf("t8w%0d_ch0", w), 64'(counts8[7:0]), 149, 151);
            chk_rng($sformatf("t8w%0d_ch1", w), 64'(counts8[15:8]), 224, 226);
        end
        cont8 = 1'b0;
        @(negedge clk); stop8 = 1'b1;
        @(negedge clk); stop8 = 1'b0;
        @(negedge clk);
        chk("t8_idle", 64'(busy8), 64'd0);

        // Reset mid-window abandons it silently.
        window_cycles = 500;
        pulse_start();
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_valid", 64'(counts_valid), 64'd0);
        chk("t6_rst_elapsed", 64'(elapsed), 64'd0);
        chk("t6_rst_counts", 64'(|counts), 64'd0);
        chk("t6_rst_err", 64'(chan_err), 64'd0);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
        end
        chk("t6_no_done", 64'(saw), 64'd0);
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_start_stop_ignored", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_clock_freq_meter.md
Name: multi_clock_freq_meter

Overview:
- Parametrised, multi-channel successor to the single-clock cycle counter used for AFU clock characterisation.
- Measures NUM_CLKS asynchronous clocks against the measurement clock clk, over a programmable window or an open-ended start/stop interval.
- Optional back-to-back continuous windows.
- Sits behind the AFU CSR decoder: start/stop/clear/mode come from CSR writes; results are read back as CSRs.

Parameters:
NUM_CLKS, 6, number of measured clock channels (1..16)
COUNTER_WIDTH, 40, width of per-channel counters, window length and results (8..64)
SYNC_STAGES, 2, synchroniser flops per crossing (>=2)

Ports:
clk  in  1  measurement/control clock
reset_n  in  1  synchronous, active-low reset in the clk domain
count_clk  in  NUM_CLKS  measured clocks, one per channel
count_reset_n  in  NUM_CLKS  per-channel reset, synchronous active-low in its own count_clk domain
start  in  1  one-cycle pulse: begin measurement
stop  in  1  one-cycle pulse: end measurement early / end open-ended window
clear  in  1  one-cycle pulse: zero results and flags
continuous  in  1  1 = restart a new window immediately at each window end
window_cycles  in  COUNTER_WIDTH  window length in clk cycles; 0 = open-ended (runs until stop)
busy  out  1  measurement in progress
done  out  1  one-cycle pulse when results update
counts_valid  out  1  results hold a completed measurement
elapsed  out  COUNTER_WIDTH  clk cycles in current/last window
counts  out  NUM_CLKS*COUNTER_WIDTH  per-channel tick counts; channel i at [i*W +: W]
chan_err  out  NUM_CLKS  channel reset was asserted during the window (sticky until clear/start)
window_overflow  out  1  open-ended window hit all-ones elapsed

Behaviour:
- Reset values: reset_n low clears all outputs to 0 and forces state IDLE. A reset mid-window abandons the window without a done pulse.
- Per-channel logic:
  - Free-running binary counter in the count_clk[i] domain, reset by count_reset_n[i].
  - Converted to Gray, registered in count_clk[i], crossed through SYNC_STAGES flops into clk, converted back to binary (sync_val[i]).
  - count_reset_n[i] is also synchronised into clk (SYNC_STAGES flops).
- States: IDLE, RUN.
  - IDLE: start=1 and stop=0 -> RUN next cycle.
    - Latch window_cycles into win_len.
    - Capture snap[i] = sync_val[i] on the same edge.
    - Clear elapsed, chan_err and window_overflow.
    - busy=1 from the next cycle.
  - IDLE with start and stop both high: ignored.
  - RUN: elapsed increments by 1 each cycle. The window ends on the cycle where any of these holds:
    - win_len!=0 and elapsed==win_len-1 (RUN lasts exactly win_len cycles; final elapsed = win_len);
    - stop=1;
    - win_len==0 and elapsed==all-ones (also sets window_overflow).
  - At window end, on the same edge:
    - counts[i] = (sync_val[i] - snap[i]) mod 2^COUNTER_WIDTH;
    - channels with chan_err[i]=1 report counts[i]=0;
    - counts_valid<=1; done pulses for one cycle on the following cycle.
    - If continuous=1 and stop=0: remain in RUN, snap[i]<=sync_val[i], elapsed restarts at 0, win_len re-latched from window_cycles (no gap cycle).
    - Otherwise: go to IDLE, busy=0.
  - start while in RUN: ignored.
- chan_err[i]: set whenever synchronised count_reset_n[i]==0 during RUN. Sticky until the next start or clear.
- clear: zeroes counts, counts_valid, chan_err, window_overflow and elapsed. It does not change state.
  - clear in RUN: the window continues.
  - clear coincident with window end: window-end update wins.
- Accuracy: each channel result is within ±1 of true ticks (crossing quantisation). Channel wrap inside a window is correct if true ticks < 2^COUNTER_WIDTH.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. count_clk[0]=clk (same source), window_cycles=1000, pulse start -> done exactly 1001 cycles after start (RUN 1000 cycles), elapsed=1000, counts[0] in 999..1001, busy low after done.
2. count_clk[1]=clk/2, count_clk[2]=clk*1.5 (async), window_cycles=10000 -> counts[1] in 4999..5001, counts[2] in 14999..15001, chan_err=0, counts_valid=1.
3. window_cycles=0, start, stop after 2500 cycles -> elapsed=2500, counts scale accordingly. Same with COUNTER_WIDTH=8 forced to all-ones -> auto-stop, window_overflow=1.
4. continuous=1, window_cycles=100 -> done every 100 cycles with no gap. Sum of counts[0] over 5 windows = 500±1. Then stop mid-window -> final partial results, IDLE.
5. Assert count_reset_n[3] low for 20 count_clk cycles mid-window -> chan_err[3]=1, counts[3]=0, other channels unaffected. Clear -> chan_err=0, counts=0, counts_valid=0.
6. Channel counter preset near wrap (0xFF..F0), window spanning wrap -> correct modular delta. reset_n low mid-RUN -> no done, all outputs 0; a start and stop pulsed together in IDLE remain ignored.
